// File: rtl/mac_fifo_pkg.sv
// Shared types, sizes and ROM contents for the FIFO-fed matrix-vector MAC array.
package mac_fifo_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ROWS   = 8;
  localparam int ACC_W  = 24;
  localparam int ROM_WORDS = ROWS + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FILLA = 3'd2,
    FILLB = 3'd3,
    MAC   = 3'd4,
    FLUSH = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Words 0..7 hold A row r (byte j = 16*(r+1)+j); word 8 holds B (byte j = j).
  // Byte 0 sits in the most significant lane of the word.
  function automatic logic [63:0] rom_word(input logic [3:0] r);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++)
      w[63-8*j -: 8] = (r < 4'(ROWS)) ? {r + 4'd1, 1'b0, 3'(j)} : {5'd0, 3'(j)};
    return w;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered read data, flags decoded from the occupancy count.
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wren,
  input  logic         rden,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [D-1:0][W-1:0] mem;
  logic [AW-1:0]       wptr, rptr;
  logic [CW-1:0]       count;
  logic                do_wr, do_rd;

  assign full  = (count == CW'(D));
  assign empty = (count == '0);
  assign do_wr = wren & ~full;
  assign do_rd = rden & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= din;
        wptr      <= (wptr == AW'(D - 1)) ? '0 : wptr + AW'(1);
      end
      if (do_rd) begin
        dout <= mem[rptr];
        rptr <= (rptr == AW'(D - 1)) ? '0 : rptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mac_fifo_array.sv
// Loads A (8x8) and B (8) from ROM into FIFOs, then computes C = A*B in eight MAC lanes.
// Define MAC_HEX_DISPLAY_EN to add HEX0..HEX5 showing the SW[2:0]-selected result.
module mac_fifo_array
  import mac_fifo_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       CLOCK2_50,
  input  logic       CLOCK3_50,
  input  logic       CLOCK4_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
`ifdef MAC_HEX_DISPLAY_EN
  ,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
`endif
);
  logic clk, rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[0];

  state_t                         state, next_state;
  logic [3:0]                     row;
  logic [2:0]                     j;
  logic [63:0]                    readdata;
  logic [DATA_W-1:0]              readdata_byte [0:7];
  logic [DATA_W-1:0]              datain, doutB;
  logic [ROWS-1:0]                wrenA, fullA, emptyA;
  logic                           wrenB, fullB, emptyB, allFull, rden;
  logic [ROWS-1:0][DATA_W-1:0]    doutA;
  logic [ROWS-1:0][ACC_W-1:0]     acc;
  logic [1:0]                     vld_pipe;
  logic [ACC_W-1:0] cout_reg_00, cout_reg_01, cout_reg_02, cout_reg_03;
  logic [ACC_W-1:0] cout_reg_04, cout_reg_05, cout_reg_06, cout_reg_07;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // READ is a single cycle: the ROM address is the row counter, so the word is
  // registered by the time FILLA/FILLB starts.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = READ;
      READ:    next_state = (row < 4'(ROWS)) ? FILLA : FILLB;
      FILLA:   if (j == 3'd7) next_state = READ;
      FILLB:   if (j == 3'd7) next_state = MAC;
      MAC:     if (&emptyA) next_state = FLUSH;
      FLUSH:   next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      j        <= '0;
      readdata <= '0;
    end else begin
      readdata <= rom_word(row);
      case (state)
        FILLA: begin
          j <= j + 3'd1;
          if (j == 3'd7) row <= row + 4'd1;
        end
        FILLB:   j <= j + 3'd1;
        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < 8; b++) begin : g_bytes
    assign readdata_byte[b] = readdata[63-8*b -: 8];
  end

  assign datain  = readdata_byte[j];
  assign wrenB   = (state == FILLB);
  assign rden    = (state == MAC);
  assign allFull = &fullA & fullB;

  // FIFO read data lands one cycle after the pop, so the accumulate trails by a stage.
  assign vld_pipe[0] = rden & ~emptyB;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  end

  sync_fifo #(.W(DATA_W), .D(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .wren(wrenB), .rden(rden), .din(datain),
    .dout(doutB), .full(fullB), .empty(emptyB)
  );

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q;

    assign wrenA[i] = (state == FILLA) && (row == 4'(i));

    sync_fifo #(.W(DATA_W), .D(DEPTH)) u_fifo_a (
      .clk(clk), .rst_n(rst_n), .wren(wrenA[i]), .rden(rden), .din(datain),
      .dout(doutA[i]), .full(fullA[i]), .empty(emptyA[i])
    );

    assign prod = {{DATA_W{1'b0}}, doutA[i]} * {{DATA_W{1'b0}}, doutB};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           acc_q <= '0;
      else if (vld_pipe[1]) acc_q <= acc_q + ACC_W'(prod);
    end
    assign acc[i] = acc_q;
  end

  assign cout_reg_00 = acc[0];
  assign cout_reg_01 = acc[1];
  assign cout_reg_02 = acc[2];
  assign cout_reg_03 = acc[3];
  assign cout_reg_04 = acc[4];
  assign cout_reg_05 = acc[5];
  assign cout_reg_06 = acc[6];
  assign cout_reg_07 = acc[7];

  assign LEDR = {state == DONE, 6'd0, state};

`ifdef MAC_HEX_DISPLAY_EN
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [ACC_W-1:0] sel;
  logic             show;
  assign sel  = acc[SW[2:0]];
  assign show = (state == DONE);
  assign HEX0 = show ? seg7(sel[3:0])   : 7'h7F;
  assign HEX1 = show ? seg7(sel[7:4])   : 7'h7F;
  assign HEX2 = show ? seg7(sel[11:8])  : 7'h7F;
  assign HEX3 = show ? seg7(sel[15:12]) : 7'h7F;
  assign HEX4 = show ? seg7(sel[19:16]) : 7'h7F;
  assign HEX5 = show ? seg7(sel[23:20]) : 7'h7F;

  logic unused_ok;
  assign unused_ok = ^{KEY[3:1], CLOCK2_50, CLOCK3_50, CLOCK4_50, SW[9:3], allFull, next_state};
`else
  logic unused_ok;
  assign unused_ok = ^{KEY[3:1], CLOCK2_50, CLOCK3_50, CLOCK4_50, SW, allFull};
`endif
endmodule

// File: tb/tb_mac_fifo_array.sv
// Scoreboard bench: expected FIFO writes are queued from the ROM rules and popped by a monitor.
module tb_mac_fifo_array;
  logic       CLOCK_50 = 1'b0;
  logic       CLOCK2_50 = 1'b0, CLOCK3_50 = 1'b0, CLOCK4_50 = 1'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
`ifdef MAC_HEX_DISPLAY_EN
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
`endif

  always #10 CLOCK_50 = ~CLOCK_50;

  mac_fifo_array dut (
    .CLOCK_50(CLOCK_50), .CLOCK2_50(CLOCK2_50), .CLOCK3_50(CLOCK3_50), .CLOCK4_50(CLOCK4_50),
    .KEY(KEY), .SW(SW), .LEDR(LEDR)
`ifdef MAC_HEX_DISPLAY_EN
    , .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
`endif
  );

  typedef struct {
    bit         is_b;
    int         row;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  bit  prev_af = 1'b0;
  bit  prev_wb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // C[i] = sum_j A[i][j]*B[j] with A[i][j] = 16*(i+1)+j and B[j] = j.
  function automatic int exp_acc(input int i);
    int s = 0;
    for (int k = 0; k < 8; k++) s += (16 * (i + 1) + k) * k;
    return s;
  endfunction

  function automatic logic [23:0] cout(input int i);
    case (i)
      0: return dut.cout_reg_00;  1: return dut.cout_reg_01;
      2: return dut.cout_reg_02;  3: return dut.cout_reg_03;
      4: return dut.cout_reg_04;  5: return dut.cout_reg_05;
      6: return dut.cout_reg_06;  default: return dut.cout_reg_07;
    endcase
  endfunction

  task automatic push_expected();
    wr_t e;
    exp_q.delete();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        e.is_b = 1'b0; e.row = r; e.data = 8'(16 * (r + 1) + k);
        exp_q.push_back(e);
      end
    for (int k = 0; k < 8; k++) begin
      e.is_b = 1'b1; e.row = 0; e.data = 8'(k);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every FIFO write the DUT presents must match the head of the queue.
  always @(negedge CLOCK_50) begin
    if (!KEY[0]) begin
      prev_af = 1'b0;
      prev_wb = 1'b0;
    end else begin
      if (dut.wrenA != 8'd0 || dut.wrenB) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {23'd0, dut.wrenB, dut.wrenA}, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_enables", {23'd0, dut.wrenB, dut.wrenA},
              e.is_b ? 32'h100 : (32'd1 << e.row));
          chk("wr_data", {24'd0, dut.datain}, {24'd0, e.data});
          if (!e.is_b) chk("wr_while_full", {31'd0, dut.fullA[e.row]}, 32'd0);
        end
      end
      if (dut.allFull && !prev_af)
        chk("allfull_after_last_b", {30'd0, prev_wb, exp_q.size() == 0}, 32'd3);
      prev_af = dut.allFull;
      prev_wb = dut.wrenB;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, {29'd0, dut.state}, 32'd0);
    chk({tag, "_ledr"}, {22'd0, LEDR}, 32'd0);
    chk({tag, "_emptyA"}, {24'd0, dut.emptyA}, 32'hFF);
    chk({tag, "_fullA"}, {24'd0, dut.fullA}, 32'd0);
    for (int i = 0; i < 8; i++) chk({tag, "_acc"}, {8'd0, cout(i)}, 32'd0);
  endtask

  task automatic start_run();
    push_expected();
    @(negedge CLOCK_50);
    KEY[0] = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 25000 && !ok; c++) begin
      @(negedge CLOCK_50);
      if (dut.state == s) ok = 1'b1;
    end
    chk({"wait_", name}, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) chk({tag, "_result"}, {8'd0, cout(i)}, exp_acc(i));
    chk({tag, "_ledr"}, {22'd0, LEDR}, 32'h206);
    chk({tag, "_emptyA"}, {24'd0, dut.emptyA}, 32'hFF);
    repeat (5) @(negedge CLOCK_50);
    chk({tag, "_hold_state"}, {29'd0, dut.state}, 32'd6);
    chk({tag, "_hold_acc7"}, {8'd0, cout(7)}, exp_acc(7));
  endtask

  initial begin
    KEY = 4'b1110;
    SW  = 10'($urandom_range(0, 1023));
    repeat ($urandom_range(2, 5)) @(negedge CLOCK_50);
    #1 check_reset("por");

    // Clean run to completion.
    start_run();
    wait_state(3'd4, "mac");
    chk("allfull_at_mac", {31'd0, dut.allFull}, 32'd1);
    wait_state(3'd6, "done1");
    check_done("run1");

    // Abort part way through the fill.
    #3 KEY[0] = 1'b0;
    #1 check_reset("rst_done");
    start_run();
    wait_state(3'd2, "filla");
    repeat ($urandom_range(1, 50)) @(negedge CLOCK_50);
    #3 KEY[0] = 1'b0;
    #1 check_reset("abort_fill");

    // Abort part way through the MAC phase.
    start_run();
    wait_state(3'd4, "mac2");
    repeat ($urandom_range(2, 7)) @(posedge CLOCK_50);
    #5 KEY[0] = 1'b0;
    #1 check_reset("abort_mac");

    // Rerun must reproduce identical results.
    start_run();
    wait_state(3'd6, "done2");
    check_done("rerun");

`ifdef MAC_HEX_DISPLAY_EN
    begin
      logic [6:0]  seg [16];
      logic [23:0] v;
      seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      SW = 10'd3;
      #1;
      v = 24'(exp_acc(3));
      chk("hex0", {25'd0, HEX0}, {25'd0, seg[v[3:0]]});
      chk("hex1", {25'd0, HEX1}, {25'd0, seg[v[7:4]]});
      chk("hex2", {25'd0, HEX2}, {25'd0, seg[v[11:8]]});
      chk("hex3", {25'd0, HEX3}, {25'd0, seg[v[15:12]]});
      chk("hex4", {25'd0, HEX4}, {25'd0, seg[v[19:16]]});
      chk("hex5", {25'd0, HEX5}, {25'd0, seg[v[23:20]]});
      KEY[0] = 1'b0;
      #1 chk("hex_blank", {25'd0, HEX0}, 32'h7F);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
